// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, control width, issue FSM state encoding and op legality check
package alu_pkg;
  localparam int CTL_W = 4;
  localparam logic [CTL_W-1:0] OP_ADD = 4'd1;
  localparam logic [CTL_W-1:0] OP_SUB = 4'd2;
  localparam logic [CTL_W-1:0] OP_MUL = 4'd3;
  localparam logic [CTL_W-1:0] OP_DIV = 4'd4;
  localparam logic [CTL_W-1:0] OP_SHR = 4'd5;
  localparam logic [CTL_W-1:0] OP_SHL = 4'd6;
  localparam logic [CTL_W-1:0] OP_ROR = 4'd7;
  localparam logic [CTL_W-1:0] OP_ROL = 4'd8;
  localparam logic [CTL_W-1:0] OP_AND = 4'd9;
  localparam logic [CTL_W-1:0] OP_OR  = 4'd10;
  localparam logic [CTL_W-1:0] OP_NOT = 4'd11;
  localparam logic [CTL_W-1:0] OP_NEG = 4'd12;
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;
  function automatic logic is_legal_op(input logic [CTL_W-1:0] op);
    return op >= OP_ADD && op <= OP_NEG;
  endfunction
endpackage

// File: rtl/alu_settle_counter.sv
// alu_settle_counter: loadable down-counter (clock, clear_n, load, load_val) that stops at zero and flags it
module alu_settle_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one req (valid/ready, op/a/b) to a combinational ALU (alu_a/b/ctl, alu_zhi/zlo), captures Z after a settle time, updates hi_q/lo_q on mul/div and returns resp (valid/ready, result/err); busy outside IDLE
module alu_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int CTL_W         = alu_pkg::CTL_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CTL_W-1:0] req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] alu_zhi,
  input  logic [WIDTH-1:0] alu_zlo,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_err,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             busy
);
  import alu_pkg::*;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  state_t state_q, state_d;
  logic [CTL_W-1:0] op_q;
  logic zero, accept, err_in;
  alu_settle_counter #(.W(4)) u_settle (
    .clock    (clock),
    .clear_n  (clear_n),
    .load     (state_q == IDLE),
    .load_val (SETTLE_INIT),
    .zero     (zero)
  );
  assign accept  = state_q == IDLE && req_valid;
  assign err_in  = !is_legal_op(req_op) || (req_op == OP_DIV && req_b == '0);
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign busy       = state_q != IDLE;
  assign alu_ctl    = (state_q == DRIVE || state_q == CAPTURE) ? op_q : '0;
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req_valid ? (err_in ? RESP : DRIVE) : IDLE;
      DRIVE:   state_d = zero ? CAPTURE : DRIVE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      op_q        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      if (accept) begin
        op_q  <= req_op;
        alu_a <= req_a;
        alu_b <= req_b;
        if (err_in) begin
          resp_result <= '0;
          resp_err    <= 1'b1;
        end
      end
      if (state_q == CAPTURE) begin
        resp_result <= alu_zlo;
        resp_err    <= 1'b0;
        if (op_q == OP_MUL || op_q == OP_DIV) begin
          hi_q <= alu_zhi;
          lo_q <= alu_zlo;
        end
      end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized self-checking bench for alu_issue_ctrl with a behavioural ALU and response model
module tb_alu_issue_ctrl;
  localparam int S = 1;
  logic clock = 1'b0, clear_n = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
  logic [3:0] req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic req_ready, resp_valid, resp_err, busy;
  logic [31:0] alu_a, alu_b, alu_zhi, alu_zlo, resp_result, hi_q, lo_q;
  logic [3:0] alu_ctl;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  alu_issue_ctrl #(.WIDTH(32), .CTL_W(4), .SETTLE_CYCLES(S)) dut (
    .clock(clock), .clear_n(clear_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctl(alu_ctl), .alu_zhi(alu_zhi), .alu_zlo(alu_zlo), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_result(resp_result), .resp_err(resp_err),
    .hi_q(hi_q), .lo_q(lo_q), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    case (c)
      4'd1:  return {32'd0, a + b};
      4'd2:  return {32'd0, a - b};
      4'd3:  return 64'(a) * 64'(b);
      4'd4:  return b == 0 ? 64'd0 : {a % b, a / b};
      4'd5:  return {32'd0, a >> b[4:0]};
      4'd6:  return {32'd0, a << b[4:0]};
      4'd7:  begin t = {a, a} >> b[4:0]; return {32'd0, t[31:0]}; end
      4'd8:  begin t = {a, a} << b[4:0]; return {32'd0, t[63:32]}; end
      4'd9:  return {32'd0, a & b};
      4'd10: return {32'd0, a | b};
      4'd11: return {32'd0, ~a};
      4'd12: return {32'd0, -a};
      default: return 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  assign {alu_zhi, alu_zlo} = alu_ref(alu_ctl, alu_a, alu_b);

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int cc, output logic bad,
                        output logic [31:0] res, output logic err);
    cc = 0; bad = 1'b0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clock); #1;
    req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      if (alu_ctl != 0) begin
        if (alu_ctl == op) cc++;
        else bad = 1'b1;
      end
      @(posedge clock); #1; lat++;
    end
    if (alu_ctl != 0) bad = 1'b1;
    res = resp_result; err = resp_err;
  endtask

  task automatic handshake;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    vectors++; if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_ctrl got rdy=%b busy=%b vld=%b err=%b exp 1 0 0 0", req_ready, busy, resp_valid, resp_err); end
    vectors++; if ({alu_a, alu_b, alu_ctl, resp_result, hi_q, lo_q} !== '0) begin miscompares++; $display("FAIL reset_data got a=%h b=%h ctl=%h res=%h hi=%h lo=%h exp all 0", alu_a, alu_b, alu_ctl, resp_result, hi_q, lo_q); end
    clear_n = 1'b1;
    @(posedge clock); #1;
    vectors++; if (alu_ctl !== 4'd0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ctl got ctl=%h rdy=%b exp 0 1", alu_ctl, req_ready); end
  endtask

  task automatic test_add;
    int lat, cc; logic bad, e; logic [31:0] r;
    run_op(4'd1, 32'd5, 32'd7, lat, cc, bad, r, e);
    vectors++; if (lat !== 2 + S) begin miscompares++; $display("FAIL add_latency got %0d exp %0d", lat, 2 + S); end
    vectors++; if (r !== 32'd12 || e !== 1'b0) begin miscompares++; $display("FAIL add_result got %h err=%b exp 0000000c err=0", r, e); end
    vectors++; if (cc !== S + 1 || bad !== 1'b0) begin miscompares++; $display("FAIL add_ctl got cycles=%0d bad=%b exp %0d 0", cc, bad, S + 1); end
    vectors++; if (hi_q !== 32'd0 || lo_q !== 32'd0) begin miscompares++; $display("FAIL add_hilo got %h %h exp 0 0", hi_q, lo_q); end
    handshake();
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL add_done got vld=%b rdy=%b exp 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_mul;
    int lat, cc; logic bad, e; logic [31:0] r;
    run_op(4'd3, 32'h0001_0000, 32'h0001_0000, lat, cc, bad, r, e);
    exp_hi = 32'd1; exp_lo = 32'd0;
    vectors++; if (r !== 32'd0 || e !== 1'b0 || lat !== 2 + S) begin miscompares++; $display("FAIL mul_resp got res=%h err=%b lat=%0d exp 0 0 %0d", r, e, lat, 2 + S); end
    vectors++; if (hi_q !== exp_hi || lo_q !== exp_lo) begin miscompares++; $display("FAIL mul_hilo got %h %h exp %h %h", hi_q, lo_q, exp_hi, exp_lo); end
    handshake();
  endtask

  task automatic test_div_zero;
    int lat, cc; logic bad, e; logic [31:0] r;
    run_op(4'd4, 32'd123, 32'd0, lat, cc, bad, r, e);
    vectors++; if (lat !== 1 || e !== 1'b1 || r !== 32'd0) begin miscompares++; $display("FAIL div0_resp got lat=%0d err=%b res=%h exp 1 1 0", lat, e, r); end
    vectors++; if (cc !== 0 || bad !== 1'b0) begin miscompares++; $display("FAIL div0_ctl got cycles=%0d bad=%b exp 0 0", cc, bad); end
    vectors++; if (hi_q !== exp_hi || lo_q !== exp_lo) begin miscompares++; $display("FAIL div0_hilo got %h %h exp %h %h", hi_q, lo_q, exp_hi, exp_lo); end
    handshake();
  endtask

  task automatic test_illegal;
    int lat, cc; logic bad, e; logic [31:0] r;
    logic [3:0] ops [3] = '{4'd13, 4'd0, 4'd15};
    foreach (ops[i]) begin
      run_op(4'd2, 32'd50, 32'd8, lat, cc, bad, r, e);
      handshake();
      run_op(ops[i], 32'd9, 32'd4, lat, cc, bad, r, e);
      vectors++; if (lat !== 1 || e !== 1'b1 || r !== 32'd0 || cc !== 0) begin miscompares++; $display("FAIL illegal_op%0d got lat=%0d err=%b res=%h ctl_cycles=%0d exp 1 1 0 0", ops[i], lat, e, r, cc); end
      vectors++; if (hi_q !== exp_hi || lo_q !== exp_lo) begin miscompares++; $display("FAIL illegal_hilo got %h %h exp %h %h", hi_q, lo_q, exp_hi, exp_lo); end
      handshake();
    end
  endtask

  task automatic test_backpressure;
    int lat, cc; logic bad, e; logic [31:0] r;
    run_op(4'd9, 32'hF0F0_1234, 32'h0FF0_FF00, lat, cc, bad, r, e);
    vectors++; if (r !== 32'h00F0_1200) begin miscompares++; $display("FAIL bp_result got %h exp 00f01200", r); end
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd1; req_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      vectors++; if (resp_valid !== 1'b1 || resp_result !== r || resp_err !== 1'b0 || req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall%0d got vld=%b res=%h err=%b rdy=%b exp 1 %h 0 0", i, resp_valid, resp_result, resp_err, req_ready, r); end
    end
    handshake();
    vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got vld=%b busy=%b rdy=%b exp 0 0 1", resp_valid, busy, req_ready); end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int lat, cc; logic bad, e; logic [31:0] r;
    req_valid = 1'b1; req_op = 4'd3; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (S) @(posedge clock);
    #1;
    vectors++; if (alu_ctl !== 4'd3 || busy !== 1'b1) begin miscompares++; $display("FAIL rst_capture got ctl=%h busy=%b exp 3 1", alu_ctl, busy); end
    clear_n = 1'b0; #1;
    exp_hi = '0; exp_lo = '0;
    vectors++; if ({alu_a, alu_b, alu_ctl, resp_result, hi_q, lo_q} !== '0) begin miscompares++; $display("FAIL rst_mid_data got a=%h b=%h ctl=%h res=%h hi=%h lo=%h exp all 0", alu_a, alu_b, alu_ctl, resp_result, hi_q, lo_q); end
    vectors++; if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ctrl got busy=%b vld=%b err=%b rdy=%b exp 0 0 0 1", busy, resp_valid, resp_err, req_ready); end
    #1 clear_n = 1'b1;
    @(posedge clock); #1;
    run_op(4'd1, 32'd5, 32'd7, lat, cc, bad, r, e);
    vectors++; if (lat !== 2 + S || r !== 32'd12 || e !== 1'b0 || hi_q !== 32'd0 || lo_q !== 32'd0) begin miscompares++; $display("FAIL rst_next_add got lat=%0d res=%h err=%b hi=%h lo=%h exp %0d c 0 0 0", lat, r, e, hi_q, lo_q, 2 + S); end
    handshake();
  endtask

  task automatic test_random;
    int lat, cc; logic bad, e; logic [31:0] r;
    logic [3:0] op; logic [31:0] a, b, res_e; logic [63:0] z; logic err_e; int stall;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      err_e = !(op >= 1 && op <= 12) || (op == 4 && b == 0);
      z = alu_ref(op, a, b);
      res_e = err_e ? 32'd0 : z[31:0];
      if (!err_e && (op == 3 || op == 4)) {exp_hi, exp_lo} = z;
      stall = $urandom_range(0, 3);
      resp_ready = stall == 0;
      run_op(op, a, b, lat, cc, bad, r, e);
      vectors++; if (lat !== (err_e ? 1 : 2 + S) || r !== res_e || e !== err_e) begin miscompares++; $display("FAIL rand%0d_op%0d got lat=%0d res=%h err=%b exp %0d %h %b", n, op, lat, r, e, err_e ? 1 : 2 + S, res_e, err_e); end
      vectors++; if (cc !== (err_e ? 0 : S + 1) || bad !== 1'b0) begin miscompares++; $display("FAIL rand%0d_ctl got cycles=%0d bad=%b exp %0d 0", n, cc, bad, err_e ? 0 : S + 1); end
      vectors++; if (hi_q !== exp_hi || lo_q !== exp_lo) begin miscompares++; $display("FAIL rand%0d_hilo got %h %h exp %h %h", n, hi_q, lo_q, exp_hi, exp_lo); end
      for (int i = 1; i < stall; i++) begin
        @(posedge clock); #1;
        vectors++; if (resp_valid !== 1'b1 || resp_result !== res_e) begin miscompares++; $display("FAIL rand%0d_hold got vld=%b res=%h exp 1 %h", n, resp_valid, resp_result, res_e); end
      end
      if (stall == 0) begin
        @(posedge clock); #1;
        resp_ready = 1'b0;
      end else handshake();
      vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rand%0d_done got vld=%b rdy=%b exp 0 1", n, resp_valid, req_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div_zero();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
